// File: rtl/argmax_input_sequencer.sv
// Feeds class scores one per cycle onto the argmax chain bus,
// tagging each with its class index and idling between frames.
module argmax_input_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLASS_AMOUNT = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] score_value,
  input  logic                  score_valid,
  output logic                  score_ready,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = $clog2(CLASS_AMOUNT);
  localparam int FW = (FLUSH_CYCLES > 1) ?
                      $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLASS_AMOUNT - 1);

  typedef enum logic {
    STREAM = 1'b0,
    FLUSH  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic                  xfer;

  assign score_ready   = (state_q == STREAM);
  assign xfer          = score_valid && score_ready;
  assign busy          = (state_q == FLUSH) || (cnt_q != '0);
  assign output_index  = idx_q;
  assign output_value  = val_q;
  assign output_enable = en_q;
  assign frame_done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    idx_d   = '0;
    val_d   = '0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      STREAM: begin
        if (xfer) begin
          val_d = score_value;
          idx_d = DATA_WIDTH'(cnt_q);
          en_d  = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              fcnt_d  = FW'(FLUSH_CYCLES);
              state_d = FLUSH;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        // Producer holds its score under backpressure here
        if (fcnt_q <= FW'(1)) begin
          state_d = STREAM;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      default: state_d = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= STREAM;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_argmax_input_sequencer.sv
// Bench for argmax_input_sequencer: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_argmax_input_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: CLASS_AMOUNT=3, FLUSH_CYCLES=2
  logic        rn_a = 1'b0, sv_a = 1'b0, srdy_a;
  logic [31:0] sval_a = '0, oi_a, ov_a;
  logic        oe_a, fd_a, busy_a;
  // DUT B: CLASS_AMOUNT=2, FLUSH_CYCLES=0
  logic        rn_b = 1'b0, sv_b = 1'b0, srdy_b;
  logic [31:0] sval_b = '0, oi_b, ov_b;
  logic        oe_b, fd_b, busy_b;

  argmax_input_sequencer #(
    .DATA_WIDTH(32), .CLASS_AMOUNT(3), .FLUSH_CYCLES(2)
  ) dut_a (
    .clk(clk), .reset_n(rn_a),
    .score_value(sval_a), .score_valid(sv_a),
    .score_ready(srdy_a), .output_index(oi_a),
    .output_value(ov_a), .output_enable(oe_a),
    .frame_done(fd_a), .busy(busy_a)
  );

  argmax_input_sequencer #(
    .DATA_WIDTH(32), .CLASS_AMOUNT(2), .FLUSH_CYCLES(0)
  ) dut_b (
    .clk(clk), .reset_n(rn_b),
    .score_value(sval_b), .score_valid(sv_b),
    .score_ready(srdy_b), .output_index(oi_b),
    .output_value(ov_b), .output_enable(oe_b),
    .frame_done(fd_b), .busy(busy_b)
  );

  // {enable, frame_done, busy, ready, index, value}
  wire [67:0] obs_a = {oe_a, fd_a, busy_a, srdy_a, oi_a, ov_a};
  wire [67:0] obs_b = {oe_b, fd_b, busy_b, srdy_b, oi_b, ov_b};

  function automatic logic [67:0] ex(
    bit e, bit f, bit b, bit r, int i, int v);
    return {e, f, b, r, 32'(i), 32'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rn_a = 1'b0; sv_a = 1'b0; sval_a = '0;
    tick();
    rn_a = 1'b1;
  endtask

  task automatic test_reset();
    rn_a = 1'b0; sv_a = 1'b1; sval_a = 32'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_a !== ex(0, 0, 0, 1, 0, 0)) begin
        errors++;
        $display("FAIL reset[%0d] got %h exp %h",
                 i, obs_a, ex(0, 0, 0, 1, 0, 0));
      end
    end
    sv_a = 1'b0; rn_a = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bit          v [5] = '{1, 1, 1, 0, 0};
    int          d [5] = '{5, 9, 2, 0, 0};
    logic [67:0] e [5];
    e[0] = ex(1, 0, 1, 1, 0, 5);
    e[1] = ex(1, 0, 1, 1, 1, 9);
    e[2] = ex(1, 1, 1, 0, 2, 2);
    e[3] = ex(0, 0, 1, 0, 0, 0);
    e[4] = ex(0, 0, 0, 1, 0, 0);
    reset_a();
    for (int i = 0; i < 5; i++) begin
      sv_a = v[i]; sval_a = 32'(d[i]);
      tick();
      checks++;
      if (obs_a !== e[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got %h exp %h", i, obs_a, e[i]);
      end
    end
  endtask

  task automatic test_bubble();
    bit          v [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
    int          d [8] = '{4, 0, 0, 0, 8, 1, 0, 0};
    logic [67:0] e [8];
    e[0] = ex(1, 0, 1, 1, 0, 4);
    e[1] = ex(0, 0, 1, 1, 0, 0);
    e[2] = ex(0, 0, 1, 1, 0, 0);
    e[3] = ex(0, 0, 1, 1, 0, 0);
    e[4] = ex(1, 0, 1, 1, 1, 8);
    e[5] = ex(1, 1, 1, 0, 2, 1);
    e[6] = ex(0, 0, 1, 0, 0, 0);
    e[7] = ex(0, 0, 0, 1, 0, 0);
    reset_a();
    for (int i = 0; i < 8; i++) begin
      sv_a = v[i]; sval_a = 32'(d[i]);
      tick();
      checks++;
      if (obs_a !== e[i]) begin
        errors++;
        $display("FAIL bubble[%0d] got %h exp %h", i, obs_a, e[i]);
      end
    end
  endtask

  task automatic test_flush_backpressure();
    bit          v [7] = '{1, 1, 1, 1, 1, 1, 0};
    int          d [7] = '{5, 9, 2, 6, 6, 6, 0};
    logic [67:0] e [7];
    int          sixes = 0;
    e[0] = ex(1, 0, 1, 1, 0, 5);
    e[1] = ex(1, 0, 1, 1, 1, 9);
    e[2] = ex(1, 1, 1, 0, 2, 2);
    e[3] = ex(0, 0, 1, 0, 0, 0);
    e[4] = ex(0, 0, 0, 1, 0, 0);
    e[5] = ex(1, 0, 1, 1, 0, 6);
    e[6] = ex(0, 0, 1, 1, 0, 0);
    reset_a();
    for (int i = 0; i < 7; i++) begin
      sv_a = v[i]; sval_a = 32'(d[i]);
      tick();
      if (oe_a && ov_a == 32'd6) sixes++;
      checks++;
      if (obs_a !== e[i]) begin
        errors++;
        $display("FAIL backpr[%0d] got %h exp %h", i, obs_a, e[i]);
      end
    end
    checks++;
    if (sixes != 1) begin
      errors++;
      $display("FAIL backpr_once got %0d exp 1", sixes);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit          r [4] = '{1, 1, 0, 1};
    int          d [4] = '{3, 3, 3, 10};
    logic [67:0] e [4];
    e[0] = ex(1, 0, 1, 1, 0, 3);
    e[1] = ex(1, 0, 1, 1, 1, 3);
    e[2] = ex(0, 0, 0, 1, 0, 0);
    e[3] = ex(1, 0, 1, 1, 0, 10);
    reset_a();
    for (int i = 0; i < 4; i++) begin
      rn_a = r[i]; sv_a = 1'b1; sval_a = 32'(d[i]);
      tick();
      checks++;
      if (obs_a !== e[i]) begin
        errors++;
        $display("FAIL rstmid[%0d] got %h exp %h", i, obs_a, e[i]);
      end
    end
    rn_a = 1'b1; sv_a = 1'b0;
  endtask

  task automatic test_no_flush();
    logic [67:0] e [4];
    e[0] = ex(1, 0, 1, 1, 0, 1);
    e[1] = ex(1, 1, 0, 1, 1, 2);
    e[2] = ex(1, 0, 1, 1, 0, 3);
    e[3] = ex(1, 1, 0, 1, 1, 4);
    rn_a = 1'b0;
    rn_b = 1'b0; sv_b = 1'b0;
    tick();
    rn_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sv_b = 1'b1; sval_b = 32'(i + 1);
      tick();
      checks++;
      if (obs_b !== e[i]) begin
        errors++;
        $display("FAIL noflush[%0d] got %h exp %h", i, obs_b, e[i]);
      end
    end
    sv_b = 1'b0;
  endtask

  // Model: ready resumes fc cycles after a frame ends; index is
  // the count of scores accepted since reset, modulo ca.
  task automatic test_random(int sel, int ca, int fc, int n);
    int          cyc = 0;
    int          ready_from = 0;
    int          nacc = 0;
    bit          r, v, rdy_prev;
    logic [31:0] d;
    logic [67:0] e, o;
    int          pos;
    for (int i = 0; i < n; i++) begin
      r = (i == 0) || ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = $urandom;
      rdy_prev = (cyc >= ready_from);
      if (sel == 0) begin
        rn_a = !r; sv_a = v; sval_a = d;
      end else begin
        rn_b = !r; sv_b = v; sval_b = d;
      end
      tick();
      cyc++;
      e = ex(0, 0, 0, 0, 0, 0);
      if (r) begin
        nacc = 0;
        ready_from = cyc;
      end else if (v && rdy_prev) begin
        pos = nacc % ca;
        nacc++;
        if (pos == ca - 1) ready_from = cyc + fc;
        e = {1'b1, pos == ca - 1, 2'b00, 32'(pos), d};
      end
      e[65] = (cyc < ready_from) || (nacc % ca != 0);
      e[64] = (cyc >= ready_from);
      o = (sel == 0) ? obs_a : obs_b;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand%0d[%0d] got %h exp %h", sel, i, o, e);
      end
    end
    if (sel == 0) sv_a = 1'b0; else sv_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubble();
    test_flush_backpressure();
    test_reset_mid_frame();
    test_random(0, 3, 2, 400);
    test_no_flush();
    test_random(1, 2, 0, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
